fpga_version_info: RTL and testbench
====================================

// Module: fpga_version_info
// PURPOSE
//  Parametrised AXI4-Lite identification block, successor of the fixed version register.
//  Returns the runtime/golden version, build timestamp, capability word, a bank of ID words,
//  an uptime-seconds counter and a byte-writable scratch register.
//  Unmapped or illegal accesses get SLVERR. Sits on the board AXI interconnect as a 64 KiB slave.
// PARAMETERS
//  VersionNumber_Gen         16'h000b      runtime image version
//  VersionNumber_Golden_Gen  16'h000b      golden image version
//  BuildTimestamp_Gen        32'h0         build time, UNIX seconds
//  NumIdWords_Gen            4             ID words, 1..8
//  IdWords_Gen               {256{1'b0}}   packed ID words; word k = bits [32k+31:32k]
//  ClockFrequencyHz_Gen      50000000      SysClk frequency, uptime prescaler
//  ScratchReset_Gen          32'h0         scratch register reset value
// PORTS
//  SysClk_ClkIn           in   1   system clock
//  SysRstN_RstIn          in   1   reset, asynchronous, active-low
//  GoldenImageN_EnaIn     in   1   0 = golden image running; asynchronous input
//  GoldenImage_ValOut     out  1   synchronised golden flag (1 = golden)
//  UptimeSec_DatOut       out  32  seconds since reset
//  AxiWriteAddr*/AxiWriteData*/AxiWriteResp*/AxiReadAddr*/AxiReadData*
//    Standard AXI4-Lite slave: 16-bit addresses, 32-bit data, 4-bit WSTRB, PROT ignored.
// BEHAVIOUR
//  Reset: all READY/VALID = 0, RESP = 2'b00, RDATA = 0, uptime = 0, scratch = ScratchReset_Gen,
//    golden sync = 0.
//  GoldenImageN_EnaIn: two-flop synchroniser; GoldenImage_ValOut = ~sync, latency 2 clocks.
//  Register map (addr[15:2] decoded, addr[1:0] ignored):
//   0x00 RO  golden ? {VersionNumber_Golden_Gen,16'h0} : {16'h0,VersionNumber_Gen}
//   0x04 RO  BuildTimestamp_Gen
//   0x08 RO  {23'h0, golden, 4'h0, NumIdWords_Gen[3:0]}
//   0x0C RW  scratch; byte lane i written only when WSTRB[i]=1
//   0x10 RO  uptime seconds
//   0x20+4k  RO  ID word k, for k < NumIdWords_Gen
//   Any other address: SLVERR (2'b10), RDATA = 0.
//   Write to any RO or unmapped address: SLVERR, no state change.
//  Uptime: prescaler counts 0..ClockFrequencyHz_Gen-1; at terminal count it wraps to 0 and the
//    seconds counter increments; 32'hFFFFFFFF wraps to 0.
//  Read FSM: R_IDLE -> R_DATA.
//   In R_IDLE with ARVALID=1: ARREADY=1 for exactly that cycle; address decoded;
//     RDATA/RRESP registered; next cycle RVALID=1.
//   R_DATA: RVALID, RDATA and RRESP held stable until RREADY=1, then R_IDLE.
//   ARREADY=0 while in R_DATA.
//   Uptime read is the value sampled in the ARREADY cycle.
//  Write FSM: W_IDLE -> W_RESP.
//   AW and W accepted independently in W_IDLE: AWREADY (WREADY) = 1 for one cycle when
//     AWVALID (WVALID) = 1 and that channel is not already latched.
//   Once both are latched (same cycle or any order), the write is performed and BVALID=1 on
//     the next cycle.
//   W_RESP: BVALID/BRESP held until BREADY=1, then W_IDLE. No AW/W accepted while BVALID=1.
//  Read and write paths are independent; both may complete in the same cycle.
//   A read of 0x0C in the same cycle as a scratch write returns the pre-write value.
//  Reset asserted mid-transaction: all FSMs return to IDLE at once; latched AW/W discarded;
//    VALIDs drop asynchronously.
// TESTING
//  T1 Reset, then read 0x00 with GoldenImageN=1 and VersionNumber_Gen=0x000b
//     -> RDATA=0x0000000b, RRESP=0, RVALID 1 cycle after ARREADY.
//  T2 GoldenImageN=0 held 3 clocks, then read 0x00 and 0x08 -> 0xb0000 for the golden value
//     (i.e. 0x000b0000); bit8=1 and [3:0]=4 in 0x08.
//  T3 Write 0x0C with data 0xA5A5A5A5, WSTRB=4'b0101, W presented 3 cycles before AW
//     -> BRESP=0; read-back = 0x00A500A5 with ScratchReset_Gen=0.
//  T4 Write 0x04, read 0x40 (NumIdWords_Gen=4) -> both SLVERR; read returns RDATA=0;
//     timestamp unchanged.
//  T5 ClockFrequencyHz_Gen=10: run 35 clocks after reset -> UptimeSec_DatOut=3;
//     read 0x10 returns 3.
//  T6 Hold RREADY/BREADY low 5 cycles -> RVALID/BVALID and data stable, ARREADY/AWREADY
//     stay 0; assert reset mid-hold -> all outputs return to reset values.

Source files
------------

// File: rtl/fpga_version_info_if.sv
// AXI4-Lite bundle (16-bit address, 32-bit data) connecting the board interconnect
// to the fpga_version_info identification block.
interface fpga_version_info_if;
  logic        AxiWriteAddrValid;
  logic        AxiWriteAddrReady;
  logic [15:0] AxiWriteAddrAddress;
  logic [2:0]  AxiWriteAddrProt;
  logic        AxiWriteDataValid;
  logic        AxiWriteDataReady;
  logic [31:0] AxiWriteDataData;
  logic [3:0]  AxiWriteDataStrobe;
  logic        AxiWriteRespValid;
  logic        AxiWriteRespReady;
  logic [1:0]  AxiWriteRespResponse;
  logic        AxiReadAddrValid;
  logic        AxiReadAddrReady;
  logic [15:0] AxiReadAddrAddress;
  logic [2:0]  AxiReadAddrProt;
  logic        AxiReadDataValid;
  logic        AxiReadDataReady;
  logic [1:0]  AxiReadDataResponse;
  logic [31:0] AxiReadDataData;

  modport master (
    output AxiWriteAddrValid, AxiWriteAddrAddress, AxiWriteAddrProt,
    input  AxiWriteAddrReady,
    output AxiWriteDataValid, AxiWriteDataData, AxiWriteDataStrobe,
    input  AxiWriteDataReady,
    input  AxiWriteRespValid, AxiWriteRespResponse,
    output AxiWriteRespReady,
    output AxiReadAddrValid, AxiReadAddrAddress, AxiReadAddrProt,
    input  AxiReadAddrReady,
    input  AxiReadDataValid, AxiReadDataResponse, AxiReadDataData,
    output AxiReadDataReady
  );

  modport slave (
    input  AxiWriteAddrValid, AxiWriteAddrAddress, AxiWriteAddrProt,
    output AxiWriteAddrReady,
    input  AxiWriteDataValid, AxiWriteDataData, AxiWriteDataStrobe,
    output AxiWriteDataReady,
    output AxiWriteRespValid, AxiWriteRespResponse,
    input  AxiWriteRespReady,
    input  AxiReadAddrValid, AxiReadAddrAddress, AxiReadAddrProt,
    output AxiReadAddrReady,
    output AxiReadDataValid, AxiReadDataResponse, AxiReadDataData,
    input  AxiReadDataReady
  );
endinterface

// File: rtl/fpga_version_info.sv
// AXI4-Lite identification slave: version, build timestamp, capabilities, ID words,
// uptime seconds and a byte-writable scratch register.
module fpga_version_info #(
  parameter logic [15:0]  VersionNumber_Gen        = 16'h000b,
  parameter logic [15:0]  VersionNumber_Golden_Gen = 16'h000b,
  parameter logic [31:0]  BuildTimestamp_Gen       = 32'h0,
  parameter int           NumIdWords_Gen           = 4,
  parameter logic [255:0] IdWords_Gen              = '0,
  parameter int           ClockFrequencyHz_Gen     = 50000000,
  parameter logic [31:0]  ScratchReset_Gen         = 32'h0
) (
  input  logic               SysClk_ClkIn,
  input  logic               SysRstN_RstIn,
  input  logic               GoldenImageN_EnaIn,
  output logic               GoldenImage_ValOut,
  output logic [31:0]        UptimeSec_DatOut,
  fpga_version_info_if.slave axi
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  localparam int PrescaleWidth = (ClockFrequencyHz_Gen > 1) ? $clog2(ClockFrequencyHz_Gen) : 1;
  localparam logic [PrescaleWidth-1:0] PrescaleLast = PrescaleWidth'(ClockFrequencyHz_Gen - 1);

  logic [1:0]               goldenSync;
  logic                     golden;
  logic [PrescaleWidth-1:0] prescaleCnt;
  logic [31:0]              uptimeSec;
  logic [31:0]              scratch;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      goldenSync  <= 2'b00;
      prescaleCnt <= '0;
      uptimeSec   <= '0;
    end else begin
      goldenSync <= {goldenSync[0], GoldenImageN_EnaIn};
      if (prescaleCnt == PrescaleLast) begin
        prescaleCnt <= '0;
        uptimeSec   <= uptimeSec + 32'd1;
      end else begin
        prescaleCnt <= prescaleCnt + PrescaleWidth'(1);
      end
    end
  end

  assign golden             = ~goldenSync[1];
  assign GoldenImage_ValOut = golden;
  assign UptimeSec_DatOut   = uptimeSec;

  // Read path: decode is combinational, data and response are registered on the AR handshake.
  logic [0:0]  readState;
  logic [13:0] readIndex;
  logic [31:0] readDataNext;
  logic [1:0]  readRespNext;
  logic        readValid;
  logic [31:0] readData;
  logic [1:0]  readResp;

  assign readIndex = axi.AxiReadAddrAddress[15:2];

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    readDataNext = '0;
    readRespNext = RespOkay;
    case (readIndex)
      14'd0:   readDataNext = golden ? {VersionNumber_Golden_Gen, 16'h0} : {16'h0, VersionNumber_Gen};
      14'd1:   readDataNext = BuildTimestamp_Gen;
      14'd2:   readDataNext = {23'h0, golden, 4'h0, 4'(NumIdWords_Gen)};
      14'd3:   readDataNext = scratch;
      14'd4:   readDataNext = uptimeSec;
      default: begin
        readRespNext = RespSlvErr;
        for (int k = 0; k < NumIdWords_Gen; k++) begin
          if (readIndex == 14'(8 + k)) begin
            readDataNext = IdWords_Gen[32*k +: 32];
            readRespNext = RespOkay;
          end
        end
      end
    endcase
  end

  assign axi.AxiReadAddrReady = SysRstN_RstIn && (readState == R_IDLE) && axi.AxiReadAddrValid;

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      readState <= R_IDLE;
      readValid <= 1'b0;
      readData  <= '0;
      readResp  <= RespOkay;
    end else begin
      case (readState)
        R_IDLE: if (axi.AxiReadAddrReady) begin
          readState <= R_DATA;
          readValid <= 1'b1;
          readData  <= readDataNext;
          readResp  <= readRespNext;
        end
        R_DATA: if (axi.AxiReadDataReady) begin
          readState <= R_IDLE;
          readValid <= 1'b0;
        end
      endcase
    end
  end

  assign axi.AxiReadDataValid    = readValid;
  assign axi.AxiReadDataData     = readData;
  assign axi.AxiReadDataResponse = readResp;

  // Write path: AW and W are latched independently; the write fires once both are held.
  logic [0:0]  writeState;
  logic        awLatched, wLatched;
  logic [13:0] awIndex;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        awAccept, wAccept, writeFire, scratchHit;
  logic [13:0] writeIndex;
  logic [31:0] writeData;
  logic [3:0]  writeStrb;
  logic        writeValid;
  logic [1:0]  writeResp;

  assign awAccept   = SysRstN_RstIn && (writeState == W_IDLE) && axi.AxiWriteAddrValid && !awLatched;
  assign wAccept    = SysRstN_RstIn && (writeState == W_IDLE) && axi.AxiWriteDataValid && !wLatched;
  assign writeIndex = awAccept ? axi.AxiWriteAddrAddress[15:2] : awIndex;
  assign writeData  = wAccept ? axi.AxiWriteDataData : wData;
  assign writeStrb  = wAccept ? axi.AxiWriteDataStrobe : wStrb;
  assign writeFire  = (awLatched || awAccept) && (wLatched || wAccept);
  assign scratchHit = (writeIndex == 14'd3);

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      writeState <= W_IDLE;
      awLatched  <= 1'b0;
      wLatched   <= 1'b0;
      awIndex    <= '0;
      wData      <= '0;
      wStrb      <= '0;
      writeValid <= 1'b0;
      writeResp  <= RespOkay;
    end else begin
      if (awAccept) begin
        awLatched <= 1'b1;
        awIndex   <= axi.AxiWriteAddrAddress[15:2];
      end
      if (wAccept) begin
        wLatched <= 1'b1;
        wData    <= axi.AxiWriteDataData;
        wStrb    <= axi.AxiWriteDataStrobe;
      end
      if (writeFire) begin
        awLatched  <= 1'b0;
        wLatched   <= 1'b0;
        writeState <= W_RESP;
        writeValid <= 1'b1;
        writeResp  <= scratchHit ? RespOkay : RespSlvErr;
      end else if ((writeState == W_RESP) && axi.AxiWriteRespReady) begin
        writeState <= W_IDLE;
        writeValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      scratch <= ScratchReset_Gen;
    end else if (writeFire && scratchHit) begin
      for (int i = 0; i < 4; i++) begin
        if (writeStrb[i]) scratch[8*i +: 8] <= writeData[8*i +: 8];
      end
    end
  end

  assign axi.AxiWriteAddrReady    = awAccept;
  assign axi.AxiWriteDataReady    = wAccept;
  assign axi.AxiWriteRespValid    = writeValid;
  assign axi.AxiWriteRespResponse = writeResp;

  // Byte offsets and PROT carry no meaning for this block.
  logic unusedBits;
  assign unusedBits = ^{axi.AxiWriteAddrAddress[1:0], axi.AxiReadAddrAddress[1:0],
                        axi.AxiWriteAddrProt, axi.AxiReadAddrProt};

endmodule

// File: tb/tb_fpga_version_info.sv
// Self-checking bench for fpga_version_info: directed scenarios plus randomized
// traffic compared against a register-map model.
module tb_fpga_version_info;
  localparam logic [15:0]  VER       = 16'h000b;
  localparam logic [15:0]  VER_G     = 16'h000b;
  localparam logic [31:0]  TIMESTAMP = 32'h6543_21AB;
  localparam int           NUM_ID    = 4;
  localparam int           FREQ      = 10;
  localparam logic [31:0]  ID0 = 32'h1D00_0001, ID1 = 32'hCAFE_0002, ID2 = 32'h0BAD_F00D, ID3 = 32'h8765_4321;
  localparam logic [255:0] ID_PACKED = {128'h0, ID3, ID2, ID1, ID0};

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        goldenN = 1'b1;
  logic        goldenFlag;
  logic [31:0] uptime;

  fpga_version_info_if bus();

  fpga_version_info #(
    .VersionNumber_Gen(VER), .VersionNumber_Golden_Gen(VER_G), .BuildTimestamp_Gen(TIMESTAMP),
    .NumIdWords_Gen(NUM_ID), .IdWords_Gen(ID_PACKED), .ClockFrequencyHz_Gen(FREQ),
    .ScratchReset_Gen(32'h0)
  ) dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rstN), .GoldenImageN_EnaIn(goldenN),
    .GoldenImage_ValOut(goldenFlag), .UptimeSec_DatOut(uptime), .axi(bus)
  );

  always #5 clk = ~clk;

  int compareCount = 0;
  int failCount = 0;
  int cyc = 0;   // rising edges since reset release
  always @(posedge clk or negedge rstN) if (!rstN) cyc <= 0; else cyc <= cyc + 1;

  logic [31:0] scratchModel = 32'h0;
  logic [31:0] idModel [NUM_ID] = '{ID0, ID1, ID2, ID3};
  logic [15:0] addrPool [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h000D, 16'h0010,
                                 16'h0014, 16'h0020, 16'h0024, 16'h0028, 16'h002C, 16'h0030};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Register map model: returns {resp, data}.
  function automatic logic [33:0] modelRead(input logic [15:0] addr, input int upCycles, input bit golden);
    int word;
    word = int'(addr) >> 2;
    if (word == 0) return {2'b00, golden ? {VER_G, 16'h0} : {16'h0, VER}};
    if (word == 1) return {2'b00, TIMESTAMP};
    if (word == 2) return {2'b00, (golden ? 32'h100 : 32'h0) + 32'(NUM_ID)};
    if (word == 3) return {2'b00, scratchModel};
    if (word == 4) return {2'b00, 32'(upCycles / FREQ)};
    if (word >= 8 && word < 8 + NUM_ID) return {2'b00, idModel[word-8]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [1:0] modelWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if ((int'(addr) >> 2) != 3) return 2'b10;
    for (int i = 0; i < 4; i++) if (strb[i]) scratchModel[8*i +: 8] = data[8*i +: 8];
    return 2'b00;
  endfunction

  task automatic rawRead(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output int upCycles);
    int waited = 0;
    bus.AxiReadAddrAddress = addr;
    bus.AxiReadAddrValid = 1'b1;
    #1;
    while (bus.AxiReadAddrReady !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    check("rd arready", bus.AxiReadAddrReady, 1);
    check("rd rvalid early", bus.AxiReadDataValid, 0);
    upCycles = cyc;
    @(negedge clk);
    bus.AxiReadAddrValid = 1'b0;
    #1;
    check("rd rvalid", bus.AxiReadDataValid, 1);
    data = bus.AxiReadDataData;
    resp = bus.AxiReadDataResponse;
    bus.AxiReadDataReady = 1'b1;
    @(negedge clk);
    bus.AxiReadDataReady = 1'b0;
    #1;
    check("rd rvalid drop", bus.AxiReadDataValid, 0);
  endtask

  task automatic rawWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, output logic [1:0] resp);
    bit awDone = 0, wDone = 0, awHs, wHs;
    int t = 0;
    bus.AxiWriteAddrAddress = addr;
    bus.AxiWriteDataData = data;
    bus.AxiWriteDataStrobe = strb;
    while (!(awDone && wDone) && t < 40) begin
      bus.AxiWriteAddrValid = !awDone && t >= awDelay;
      bus.AxiWriteDataValid = !wDone && t >= wDelay;
      #1;
      awHs = bus.AxiWriteAddrValid && bus.AxiWriteAddrReady;
      wHs  = bus.AxiWriteDataValid && bus.AxiWriteDataReady;
      @(negedge clk);
      if (awHs) awDone = 1;
      if (wHs) wDone = 1;
      t++;
    end
    bus.AxiWriteAddrValid = 1'b0;
    bus.AxiWriteDataValid = 1'b0;
    check("wr both accepted", {30'h0, awDone, wDone}, 32'h3);
    #1;
    check("wr bvalid", bus.AxiWriteRespValid, 1);
    resp = bus.AxiWriteRespResponse;
    bus.AxiWriteRespReady = 1'b1;
    @(negedge clk);
    bus.AxiWriteRespReady = 1'b0;
    #1;
    check("wr bvalid drop", bus.AxiWriteRespValid, 0);
  endtask

  task automatic readModel(input logic [15:0] addr);
    logic [31:0] data; logic [1:0] resp; int up; logic [33:0] m;
    rawRead(addr, data, resp, up);
    m = modelRead(addr, up, !goldenN);
    check($sformatf("rd %04h data", addr), data, m[31:0]);
    check($sformatf("rd %04h resp", addr), {30'h0, resp}, {30'h0, m[33:32]});
  endtask

  task automatic writeModel(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDelay, input int wDelay);
    logic [1:0] resp, expResp;
    rawWrite(addr, data, strb, awDelay, wDelay, resp);
    expResp = modelWrite(addr, data, strb);
    check($sformatf("wr %04h resp", addr), {30'h0, resp}, {30'h0, expResp});
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    scratchModel = 32'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required completion within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] data, holdExp, preScratch;
    logic [1:0] resp, wResp;
    logic [33:0] m;
    int up;

    bus.AxiWriteAddrValid = 0; bus.AxiWriteAddrAddress = 0; bus.AxiWriteAddrProt = 0;
    bus.AxiWriteDataValid = 0; bus.AxiWriteDataData = 0; bus.AxiWriteDataStrobe = 0;
    bus.AxiWriteRespReady = 0;
    bus.AxiReadAddrValid = 0; bus.AxiReadAddrAddress = 0; bus.AxiReadAddrProt = 0;
    bus.AxiReadDataReady = 0;

    // Reset state
    @(negedge clk); #1;
    check("rst rvalid", bus.AxiReadDataValid, 0);
    check("rst bvalid", bus.AxiWriteRespValid, 0);
    check("rst rdata", bus.AxiReadDataData, 0);
    check("rst rresp", bus.AxiReadDataResponse, 0);
    check("rst bresp", bus.AxiWriteRespResponse, 0);
    check("rst uptime", uptime, 0);
    check("rst golden", goldenFlag, 1);
    @(negedge clk);
    rstN = 1'b1;

    // Golden synchroniser latency: two edges
    @(negedge clk); check("golden after 1 edge", goldenFlag, 1);
    @(negedge clk); check("golden after 2 edges", goldenFlag, 0);

    // T1 runtime version
    rawRead(16'h0000, data, resp, up);
    check("T1 version", data, 32'h0000_000b);
    check("T1 resp", resp, 0);

    // T2 golden image
    goldenN = 1'b0;
    repeat (3) @(negedge clk);
    check("T2 golden flag", goldenFlag, 1);
    rawRead(16'h0000, data, resp, up);
    check("T2 golden version", data, 32'h000b_0000);
    rawRead(16'h0008, data, resp, up);
    check("T2 capability", data, 32'h0000_0104);
    goldenN = 1'b1;
    repeat (3) @(negedge clk);
    check("T2 golden released", goldenFlag, 0);

    // T3 partial scratch write with W leading AW by 3 cycles
    rawWrite(16'h000C, 32'hA5A5_A5A5, 4'b0101, 3, 0, wResp);
    check("T3 bresp", wResp, 0);
    void'(modelWrite(16'h000C, 32'hA5A5_A5A5, 4'b0101));
    rawRead(16'h000C, data, resp, up);
    check("T3 scratch", data, 32'h00A5_00A5);

    // T4 illegal write and unmapped read
    rawWrite(16'h0004, 32'hFFFF_FFFF, 4'hF, 0, 0, wResp);
    check("T4 bresp", wResp, 2'b10);
    rawRead(16'h0040, data, resp, up);
    check("T4 rresp", resp, 2'b10);
    check("T4 rdata", data, 0);
    rawRead(16'h0004, data, resp, up);
    check("T4 timestamp", data, TIMESTAMP);

    // ID-word window edges, ignored byte offsets, other write orderings
    readModel(16'h0020);
    readModel(16'h002C);
    readModel(16'h0030);
    readModel(16'h001C);
    readModel(16'h0014);
    readModel(16'h000F);
    writeModel(16'h000E, 32'h7700_0000, 4'b1000, 0, 2);
    writeModel(16'h8000, 32'h1234_5678, 4'hF, 1, 1);
    writeModel(16'h0010, 32'h1234_5678, 4'hF, 0, 0);
    readModel(16'h000C);

    // Read of scratch in the same cycle as a scratch write returns the old value
    preScratch = scratchModel;
    fork
      rawWrite(16'h000C, 32'hDEAD_BEEF, 4'hF, 0, 0, wResp);
      rawRead(16'h000C, data, resp, up);
    join
    check("same-cycle read old", data, preScratch);
    check("same-cycle bresp", wResp, 0);
    void'(modelWrite(16'h000C, 32'hDEAD_BEEF, 4'hF));
    readModel(16'h000C);

    // T5 uptime with a 10-clock second
    applyReset();
    repeat (29) @(negedge clk);
    check("T5 uptime 29 clk", uptime, 2);
    @(negedge clk);
    check("T5 uptime 30 clk", uptime, 3);
    repeat (5) @(negedge clk);
    check("T5 uptime 35 clk", uptime, 3);
    rawRead(16'h0010, data, resp, up);
    check("T5 read uptime", data, 3);

    // Randomized traffic
    for (int n = 0; n < 70; n++) begin
      int kind;
      logic [15:0] addr;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) addr = 16'($urandom);
      else addr = addrPool[$urandom_range(0, 11)];
      if (kind == 0) begin
        goldenN = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
      end else if (kind <= 4) begin
        if (kind <= 2) addr = 16'h000C;
        writeModel(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        readModel(addr);
      end
    end

    // T6 stall both responses, probe that nothing new is accepted, then reset mid-hold
    @(negedge clk);
    bus.AxiReadAddrAddress = 16'h0008; bus.AxiReadAddrValid = 1'b1;
    bus.AxiWriteAddrAddress = 16'h000C; bus.AxiWriteAddrValid = 1'b1;
    bus.AxiWriteDataData = 32'h1234_5678; bus.AxiWriteDataStrobe = 4'hF; bus.AxiWriteDataValid = 1'b1;
    #1;
    check("T6 arready", bus.AxiReadAddrReady, 1);
    check("T6 awready", bus.AxiWriteAddrReady, 1);
    check("T6 wready", bus.AxiWriteDataReady, 1);
    m = modelRead(16'h0008, 0, !goldenN);
    holdExp = m[31:0];
    void'(modelWrite(16'h000C, 32'h1234_5678, 4'hF));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("T6 rvalid held", bus.AxiReadDataValid, 1);
      check("T6 rdata held", bus.AxiReadDataData, holdExp);
      check("T6 rresp held", bus.AxiReadDataResponse, 0);
      check("T6 arready blocked", bus.AxiReadAddrReady, 0);
      check("T6 bvalid held", bus.AxiWriteRespValid, 1);
      check("T6 bresp held", bus.AxiWriteRespResponse, 0);
      check("T6 awready blocked", bus.AxiWriteAddrReady, 0);
      check("T6 wready blocked", bus.AxiWriteDataReady, 0);
      @(negedge clk);
    end
    #2;
    rstN = 1'b0;
    scratchModel = 32'h0;
    #1;
    check("T6 rst rvalid", bus.AxiReadDataValid, 0);
    check("T6 rst bvalid", bus.AxiWriteRespValid, 0);
    check("T6 rst arready", bus.AxiReadAddrReady, 0);
    check("T6 rst awready", bus.AxiWriteAddrReady, 0);
    check("T6 rst wready", bus.AxiWriteDataReady, 0);
    check("T6 rst rdata", bus.AxiReadDataData, 0);
    check("T6 rst rresp", bus.AxiReadDataResponse, 0);
    check("T6 rst bresp", bus.AxiWriteRespResponse, 0);
    check("T6 rst uptime", uptime, 0);
    check("T6 rst golden", goldenFlag, 1);
    bus.AxiReadAddrValid = 1'b0;
    bus.AxiWriteAddrValid = 1'b0;
    bus.AxiWriteDataValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    readModel(16'h000C);
    readModel(16'h0008);
    writeModel(16'h000C, 32'h0F0F_0F0F, 4'b0011, 2, 0);
    readModel(16'h000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
